// File: rtl/reg_file_cmd_ctrl_pkg.sv
// Shared definitions for the register-file command controller:
// frame command bytes and the gray-coded FSM state encoding.
`default_nettype none

package reg_file_cmd_ctrl_pkg;

    localparam logic [7:0] CMD_WR = 8'hAA;
    localparam logic [7:0] CMD_RD = 8'hBB;

    // Gray sequence along the usual paths: IDLE->WR_ADDR->WR_DATA, IDLE->RD_ADDR->RD_WAIT->TX_SEND
    typedef enum logic [2:0] {
        ST_IDLE    = 3'b000,
        ST_WR_ADDR = 3'b001,
        ST_WR_DATA = 3'b011,
        ST_RD_ADDR = 3'b010,
        ST_RD_WAIT = 3'b110,
        ST_TX_SEND = 3'b111
    } state_e;

endpackage : reg_file_cmd_ctrl_pkg

`default_nettype wire

// File: rtl/reg_file_cmd_ctrl.sv
// Parses UART byte frames into register-file write/read strobes and
// forwards read data to the UART transmitter.
`default_nettype none

module reg_file_cmd_ctrl
    import reg_file_cmd_ctrl_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int ADDRESS_SIZE = 4,
    parameter int RD_TIMEOUT   = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [WIDTH-1:0]        rx_data,
    input  logic                    rx_data_valid,
    input  logic [WIDTH-1:0]        rd_data,
    input  logic                    rd_data_valid,
    input  logic                    tx_busy,
    output logic                    wr_en,
    output logic                    rd_en,
    output logic [ADDRESS_SIZE-1:0] address,
    output logic [WIDTH-1:0]        wr_data,
    output logic [WIDTH-1:0]        tx_data,
    output logic                    tx_data_valid,
    output logic                    rd_timeout
);

    localparam int              CNT_W    = $clog2(RD_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_TIMEOUT - 1);
    localparam logic [WIDTH-1:0] W_CMD_WR = WIDTH'(CMD_WR);
    localparam logic [WIDTH-1:0] W_CMD_RD = WIDTH'(CMD_RD);

    state_e                  state_q;
    logic [CNT_W-1:0]        cnt_q;
    logic                    wr_en_q;
    logic                    rd_en_q;
    logic [ADDRESS_SIZE-1:0] address_q;
    logic [WIDTH-1:0]        wr_data_q;
    logic [WIDTH-1:0]        tx_data_q;
    logic                    tx_valid_q;
    logic                    rd_timeout_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            wr_en_q      <= 1'b0;
            rd_en_q      <= 1'b0;
            address_q    <= '0;
            wr_data_q    <= '0;
            tx_data_q    <= '0;
            tx_valid_q   <= 1'b0;
            rd_timeout_q <= 1'b0;
        end else begin
            // Strobes default low so each one lasts exactly one cycle
            wr_en_q      <= 1'b0;
            rd_en_q      <= 1'b0;
            tx_valid_q   <= 1'b0;
            rd_timeout_q <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (rx_data_valid) begin
                        if (rx_data == W_CMD_WR) begin
                            state_q <= ST_WR_ADDR;
                        end else if (rx_data == W_CMD_RD) begin
                            state_q <= ST_RD_ADDR;
                        end
                    end
                end

                ST_WR_ADDR: begin
                    if (rx_data_valid) begin
                        address_q <= rx_data[ADDRESS_SIZE-1:0];
                        state_q   <= ST_WR_DATA;
                    end
                end

                ST_WR_DATA: begin
                    if (rx_data_valid) begin
                        wr_data_q <= rx_data;
                        wr_en_q   <= 1'b1;
                        state_q   <= ST_IDLE;
                    end
                end

                ST_RD_ADDR: begin
                    if (rx_data_valid) begin
                        address_q <= rx_data[ADDRESS_SIZE-1:0];
                        rd_en_q   <= 1'b1;
                        cnt_q     <= '0;
                        state_q   <= ST_RD_WAIT;
                    end
                end

                ST_RD_WAIT: begin
                    if (rd_data_valid) begin
                        tx_data_q <= rd_data;
                        cnt_q     <= '0;
                        // Idle transmitter: hand the byte over straight away
                        if (!tx_busy) begin
                            tx_valid_q <= 1'b1;
                            state_q    <= ST_IDLE;
                        end else begin
                            state_q <= ST_TX_SEND;
                        end
                    end else if (cnt_q == CNT_LAST) begin
                        rd_timeout_q <= 1'b1;
                        cnt_q        <= '0;
                        state_q      <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                ST_TX_SEND: begin
                    if (!tx_busy) begin
                        tx_valid_q <= 1'b1;
                        state_q    <= ST_IDLE;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign wr_en         = wr_en_q;
    assign rd_en         = rd_en_q;
    assign address       = address_q;
    assign wr_data       = wr_data_q;
    assign tx_data       = tx_data_q;
    assign tx_data_valid = tx_valid_q;
    assign rd_timeout    = rd_timeout_q;

endmodule : reg_file_cmd_ctrl

`default_nettype wire

// File: tb/tb_reg_file_cmd_ctrl.sv
// Directed bench for reg_file_cmd_ctrl with a small register-file model.
`default_nettype none

module tb_reg_file_cmd_ctrl;

    localparam int WIDTH        = 8;
    localparam int ADDRESS_SIZE = 4;
    localparam int RD_TIMEOUT   = 8;

    logic                    clk;
    logic                    rst;
    logic [WIDTH-1:0]        rx_data;
    logic                    rx_data_valid;
    logic [WIDTH-1:0]        rd_data;
    logic                    rd_data_valid;
    logic                    tx_busy;
    logic                    wr_en;
    logic                    rd_en;
    logic [ADDRESS_SIZE-1:0] address;
    logic [WIDTH-1:0]        wr_data;
    logic [WIDTH-1:0]        tx_data;
    logic                    tx_data_valid;
    logic                    rd_timeout;

    int n_total;
    int n_bad;
    int wr_pulses;
    int both_high;
    int tx_pulses;
    logic model_en;
    logic [WIDTH-1:0] mem [2**ADDRESS_SIZE];

    reg_file_cmd_ctrl #(
        .WIDTH        (WIDTH),
        .ADDRESS_SIZE (ADDRESS_SIZE),
        .RD_TIMEOUT   (RD_TIMEOUT)
    ) u_dut (
        .clk           (clk),
        .rst           (rst),
        .rx_data       (rx_data),
        .rx_data_valid (rx_data_valid),
        .rd_data       (rd_data),
        .rd_data_valid (rd_data_valid),
        .tx_busy       (tx_busy),
        .wr_en         (wr_en),
        .rd_en         (rd_en),
        .address       (address),
        .wr_data       (wr_data),
        .tx_data       (tx_data),
        .tx_data_valid (tx_data_valid),
        .rd_timeout    (rd_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register-file model: write on wr_en, answer rd_en one cycle later
    always @(posedge clk) begin
        if (wr_en) mem[address] <= wr_data;
        rd_data_valid <= rd_en && model_en;
        rd_data       <= mem[address];
    end

    always @(negedge clk) begin
        if (wr_en) wr_pulses++;
        if (tx_data_valid) tx_pulses++;
        if (wr_en && rd_en) both_high++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one byte for one cycle; returns 1 time unit after the sampling edge
    task automatic send_byte(input logic [WIDTH-1:0] b);
        rx_data       = b;
        rx_data_valid = 1'b1;
        tick();
        rx_data_valid = 1'b0;
    endtask

    initial begin
        int n;
        int w0;
        int t0;
        n_total = 0; n_bad = 0; wr_pulses = 0; both_high = 0; tx_pulses = 0;
        for (int i = 0; i < 2**ADDRESS_SIZE; i++) mem[i] = '0;
        rst = 1'b0; rx_data = '0; rx_data_valid = 1'b0; tx_busy = 1'b0; model_en = 1'b1;
        rd_data = '0; rd_data_valid = 1'b0;
        repeat (3) tick();
        check_eq("reset_outputs", {wr_en, rd_en, tx_data_valid, rd_timeout, address, wr_data, tx_data}, 32'h0);
        rst = 1'b1;
        tick();

        // 1: write AA,05,3C
        send_byte(8'hAA); send_byte(8'h05); send_byte(8'h3C);
        check_eq("t1_wr_en", wr_en, 1);
        check_eq("t1_addr", address, 5);
        check_eq("t1_wr_data", wr_data, 8'h3C);
        check_eq("t1_rd_en", rd_en, 0);
        tick();
        check_eq("t1_wr_en_drop", wr_en, 0);
        check_eq("t1_wr_data_hold", wr_data, 8'h3C);

        // 2: read BB,05, transmitter idle
        send_byte(8'hBB); send_byte(8'h05);
        check_eq("t2_rd_en", rd_en, 1);
        check_eq("t2_addr", address, 5);
        tick();
        check_eq("t2_rd_en_drop", rd_en, 0);
        check_eq("t2_txv_early", tx_data_valid, 0);
        tick();
        check_eq("t2_txv", tx_data_valid, 1);
        check_eq("t2_tx_data", tx_data, 8'h3C);
        tick();
        check_eq("t2_txv_drop", tx_data_valid, 0);

        // 3: read with transmitter busy for 20 cycles, stray bytes in between
        tx_busy = 1'b1;
        w0 = wr_pulses; t0 = tx_pulses;
        send_byte(8'hBB); send_byte(8'h05);
        for (int i = 0; i < 20; i++) begin
            rx_data       = (i == 4) ? 8'hAA : (i == 6) ? 8'h06 : 8'h77;
            rx_data_valid = (i == 4 || i == 6 || i == 8);
            tick();
        end
        rx_data_valid = 1'b0;
        check_eq("t3_txv_held", tx_pulses - t0, 0);
        tx_busy = 1'b0;
        tick();
        check_eq("t3_txv", tx_data_valid, 1);
        check_eq("t3_tx_data", tx_data, 8'h3C);
        tick();
        check_eq("t3_txv_drop", tx_data_valid, 0);
        repeat (3) tick();
        check_eq("t3_no_write", wr_pulses - w0, 0);
        check_eq("t3_one_tx", tx_pulses - t0, 1);

        // 4: read timeout, then a clean write
        model_en = 1'b0;
        send_byte(8'hBB); send_byte(8'h02);
        n = 0;
        while (!rd_timeout && n < 3 * RD_TIMEOUT) begin
            tick();
            n++;
        end
        check_eq("t4_timeout_cycles", n, 8);
        tick();
        check_eq("t4_timeout_drop", rd_timeout, 0);
        model_en = 1'b1;
        send_byte(8'hAA); send_byte(8'h01); send_byte(8'hFF);
        check_eq("t4_wr_en", wr_en, 1);
        check_eq("t4_addr", address, 1);
        check_eq("t4_wr_data", wr_data, 8'hFF);
        tick();

        // 5: junk byte dropped, upper address bits masked
        send_byte(8'h55); send_byte(8'hAA); send_byte(8'hF3);
        check_eq("t5_no_early_wr", wr_en, 0);
        send_byte(8'h11);
        check_eq("t5_wr_en", wr_en, 1);
        check_eq("t5_addr", address, 3);
        check_eq("t5_wr_data", wr_data, 8'h11);
        tick();

        // 6: reset mid-frame
        send_byte(8'hAA); send_byte(8'h07);
        #2 rst = 1'b0;
        #1;
        check_eq("t6_reset_outputs", {wr_en, rd_en, tx_data_valid, rd_timeout, address, wr_data, tx_data}, 32'h0);
        tick();
        rst = 1'b1;
        tick();
        w0 = wr_pulses;
        send_byte(8'h22);
        check_eq("t6_no_wr_en", wr_en, 0);
        tick();
        check_eq("t6_no_write", wr_pulses - w0, 0);
        check_eq("t6_addr_zero", address, 0);

        check_eq("never_wr_and_rd", both_high, 0);
        check_eq("mem5", mem[5], 8'h3C);
        check_eq("mem3", mem[3], 8'h11);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_reg_file_cmd_ctrl

`default_nettype wire
